// File: rtl/route_allocator.sv
// route_allocator: dimension-order route compute, per-output round-robin allocation and path locking
module route_allocator #(
    parameter int CHANNEL_NUMBER      = 5,
    parameter int MAX_ROUTERS_X       = 4,
    parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y       = 4,
    parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
    parameter int ROUTER_X            = 0,
    parameter int ROUTER_Y            = 0,
    parameter int ROUTING_MODE        = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [CHANNEL_NUMBER-1:0]                     in_valid_i,
    input  logic [CHANNEL_NUMBER-1:0]                     in_last_i,
    input  logic [CHANNEL_NUMBER*MAX_ROUTERS_X_WIDTH-1:0] target_x_i,
    input  logic [CHANNEL_NUMBER*MAX_ROUTERS_Y_WIDTH-1:0] target_y_i,
    output logic [CHANNEL_NUMBER-1:0]                     in_ready_o,
    input  logic [CHANNEL_NUMBER-1:0]                     out_ready_i,
    output logic [CHANNEL_NUMBER-1:0]                     out_valid_o,
    output logic [CHANNEL_NUMBER*CHANNEL_NUMBER-1:0]      out_sel_o
);
    localparam int CH = CHANNEL_NUMBER;
    localparam int XW = MAX_ROUTERS_X_WIDTH;
    localparam int YW = MAX_ROUTERS_Y_WIDTH;
    localparam int PW = CH > 1 ? $clog2(CH) : 1;
    localparam logic [XW-1:0] RX = XW'(ROUTER_X);
    localparam logic [YW-1:0] RY = YW'(ROUTER_Y);

    typedef enum logic [1:0] {IDLE, ROUTED, ACTIVE} in_state_e;

    in_state_e     st_q  [CH];
    in_state_e     st_d  [CH];
    logic [CH-1:0] dir_q [CH];
    logic [CH-1:0] dir_d [CH];
    logic [CH-1:0] own_q [CH];
    logic [CH-1:0] own_d [CH];
    logic [PW-1:0] ptr_q [CH];
    logic [PW-1:0] ptr_d [CH];
    logic [CH-1:0] lock_q, lock_d;

    // Port map: 0=local, 1=north(y-), 2=east(x+), 3=south(y+), 4=west(x-); result is one-hot
    function automatic logic [CH-1:0] route_dir(input logic [XW-1:0] tx, input logic [YW-1:0] ty);
        logic [4:0] d;
        if (tx == RX && ty == RY)
            d = 5'b00001;
        else if ((ROUTING_MODE == 0 && tx != RX) || (ROUTING_MODE != 0 && ty == RY))
            d = tx > RX ? 5'b00100 : 5'b10000;
        else
            d = ty < RY ? 5'b00010 : 5'b01000;
        return CH'(d);
    endfunction

    // State register: input FSMs, registered directions, output locks, owners and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= IDLE;
                dir_q[i] <= '0;
                own_q[i] <= '0;
                ptr_q[i] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            st_q   <= st_d;
            dir_q  <= dir_d;
            own_q  <= own_d;
            ptr_q  <= ptr_d;
        end
    end

    // Next state: release on last transfer, round-robin grant on free outputs, route capture on head
    always_comb begin
        int best, rank, p, win;
        logic [CH-1:0] gnt;
        best   = CH;
        rank   = 0;
        p      = 0;
        win    = 0;
        gnt    = '0;
        st_d   = st_q;
        dir_d  = dir_q;
        own_d  = own_q;
        ptr_d  = ptr_q;
        lock_d = lock_q;
        for (int j = 0; j < CH; j++) begin
            if (lock_q[j]) begin
                for (int i = 0; i < CH; i++)
                    if (own_q[j][i] && in_valid_i[i] && in_last_i[i] && out_ready_i[j]) begin
                        lock_d[j] = 1'b0;
                        st_d[i]   = IDLE;
                    end
            end else begin
                best = CH;
                win  = 0;
                gnt  = '0;
                p    = int'(ptr_q[j]);
                for (int i = 0; i < CH; i++)
                    if (st_q[i] == ROUTED && dir_q[i][j]) begin
                        rank = i >= p ? i - p : i + CH - p;
                        if (rank < best) begin
                            best   = rank;
                            win    = i;
                            gnt    = '0;
                            gnt[i] = 1'b1;
                        end
                    end
                if (best < CH) begin
                    lock_d[j] = 1'b1;
                    own_d[j]  = gnt;
                    ptr_d[j]  = PW'(win == CH - 1 ? 0 : win + 1);
                    for (int i = 0; i < CH; i++)
                        if (gnt[i]) st_d[i] = ACTIVE;
                end
            end
        end
        for (int i = 0; i < CH; i++)
            if (st_q[i] == IDLE && in_valid_i[i]) begin
                st_d[i]  = ROUTED;
                dir_d[i] = route_dir(target_x_i[i*XW +: XW], target_y_i[i*YW +: YW]);
            end
    end

    // Outputs: locked paths steer select, forward valid downstream and ready upstream
    always_comb begin
        in_ready_o  = '0;
        out_valid_o = '0;
        out_sel_o   = '0;
        for (int j = 0; j < CH; j++)
            if (lock_q[j]) begin
                out_sel_o[j*CH +: CH] = own_q[j];
                out_valid_o[j]        = |(own_q[j] & in_valid_i);
                in_ready_o            = in_ready_o | (own_q[j] & {CH{out_ready_i[j]}});
            end
    end
endmodule

// File: tb/tb_route_allocator.sv
// tb_route_allocator: directed checks of routing, allocation, locking, backpressure and reset
module tb_route_allocator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  in_valid, in_last, out_ready;
    logic [9:0]  tx, ty;
    logic [4:0]  a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [24:0] a_sel, b_sel;
    int          n_chk = 0;
    int          n_fail = 0;
    int          beats [5];
    logic [4:0]  sb [5][$];

    route_allocator #(.ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(0)) dut_xy (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
        .target_x_i(tx), .target_y_i(ty), .in_ready_o(a_in_ready),
        .out_ready_i(out_ready), .out_valid_o(a_out_valid), .out_sel_o(a_sel)
    );

    route_allocator #(.ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(1)) dut_yx (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
        .target_x_i(tx), .target_y_i(ty), .in_ready_o(b_in_ready),
        .out_ready_i(out_ready), .out_valid_o(b_out_valid), .out_sel_o(b_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = beats[i] > 0;
            in_last[i]  = beats[i] == 1;
        end
    endtask

    task automatic send(input int i, input logic [1:0] x, input logic [1:0] y, input int n);
        tx[i*2 +: 2] = x;
        ty[i*2 +: 2] = y;
        beats[i]     = n;
        drive();
        #1;
    endtask

    task automatic push(input int j, input logic [4:0] sel, input int n);
        repeat (n) sb[j].push_back(sel);
    endtask

    // Score every output transfer of this cycle, advance sources, step to the next cycle
    task automatic cyc();
        logic [4:0] e;
        for (int j = 0; j < 5; j++)
            if (a_out_valid[j] && out_ready[j]) begin
                if (sb[j].size() == 0) chk("sb_underflow", sb[j].size(), 1);
                else begin
                    e = sb[j].pop_front();
                    chk("sb_sel", a_sel[j*5 +: 5], e);
                end
            end
        for (int i = 0; i < 5; i++)
            if (in_valid[i] && a_in_ready[i]) beats[i]--;
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        tx        = '0;
        ty        = '0;
        out_ready = '1;
        for (int i = 0; i < 5; i++) beats[i] = 0;
        drive();
        #2;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_ready", a_in_ready, 0);
        chk("rst_sel", a_sel, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        // XY east vs YX north, 4-beat packet, target change after head ignored
        send(0, 3, 0, 4);
        push(2, 5'b00001, 4);
        cyc();
        chk("A_c1_valid", a_out_valid, 0);
        chk("A_c1_ready", a_in_ready, 0);
        tx[1:0] = 2'd0;
        ty[1:0] = 2'd0;
        #1;
        cyc();
        chk("A_c2_sel2", a_sel[14:10], 5'b00001);
        chk("A_c2_valid", a_out_valid, 5'b00100);
        chk("A_c2_ready", a_in_ready, 5'b00001);
        chk("YX_c2_valid", b_out_valid, 5'b00010);
        chk("YX_c2_sel1", b_sel[9:5], 5'b00001);
        repeat (4) cyc();
        chk("A_c6_free", a_sel, 0);
        chk("A_beats", beats[0], 0);
        // Own coordinate goes local in both modes
        send(0, 1, 1, 1);
        push(0, 5'b00001, 1);
        cyc();
        cyc();
        chk("B_local_sel0", a_sel[4:0], 5'b00001);
        chk("YX_local_valid", b_out_valid, 5'b00001);
        cyc();
        chk("B_free", a_out_valid, 0);
        // Inputs 1 and 3 contend for east: 1 first, 3 after the bubble
        send(1, 3, 1, 2);
        send(3, 3, 1, 1);
        push(2, 5'b00010, 2);
        push(2, 5'b01000, 1);
        cyc();
        cyc();
        chk("C_win1", a_sel[14:10], 5'b00010);
        cyc();
        cyc();
        chk("C_bubble_valid", a_out_valid, 0);
        chk("C_bubble_ready", a_in_ready, 0);
        cyc();
        chk("C_win3", a_sel[14:10], 5'b01000);
        cyc();
        chk("C_free", a_out_valid, 0);
        // U-turn single beat, then pointer=3 favours input 3 over input 1
        send(2, 3, 1, 1);
        push(2, 5'b00100, 1);
        push(2, 5'b01000, 1);
        push(2, 5'b00010, 1);
        cyc();
        send(1, 3, 1, 1);
        send(3, 3, 1, 1);
        cyc();
        chk("D_uturn", a_sel[14:10], 5'b00100);
        cyc();
        chk("D_free_c3", a_out_valid, 0);
        cyc();
        chk("D_rr_win3", a_sel[14:10], 5'b01000);
        cyc();
        cyc();
        chk("D_then1", a_sel[14:10], 5'b00010);
        cyc();
        // Backpressure on east holds the lock; local output keeps working
        send(0, 3, 1, 4);
        push(2, 5'b00001, 4);
        cyc();
        cyc();
        chk("E_locked", a_sel[14:10], 5'b00001);
        cyc();
        out_ready[2] = 1'b0;
        send(1, 1, 1, 1);
        push(0, 5'b00010, 1);
        chk("E_bp_ready", a_in_ready[0], 0);
        cyc();
        cyc();
        chk("E_other_sel", a_sel[4:0], 5'b00010);
        chk("E_other_ready", a_in_ready[1], 1);
        repeat (8) cyc();
        chk("E_lock_held", a_sel[14:10], 5'b00001);
        chk("E_valid_held", a_out_valid[2], 1);
        chk("E_no_loss", beats[0], 3);
        out_ready[2] = 1'b1;
        #1;
        for (int k = 0; k < 20 && beats[0] != 0; k++) cyc();
        chk("E_drain", beats[0], 0);
        cyc();
        chk("E_sb2_empty", sb[2].size(), 0);
        // Asynchronous reset mid-packet, then a fresh head relocks after two cycles
        send(0, 3, 1, 3);
        push(2, 5'b00001, 3);
        cyc();
        cyc();
        chk("F_locked", a_sel[14:10], 5'b00001);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_rst_valid", a_out_valid, 0);
        chk("F_rst_ready", a_in_ready, 0);
        chk("F_rst_sel", a_sel, 0);
        for (int i = 0; i < 5; i++) begin
            beats[i] = 0;
            sb[i].delete();
        end
        drive();
        cyc();
        rst_n = 1'b1;
        #1;
        send(0, 3, 1, 2);
        push(2, 5'b00001, 2);
        cyc();
        chk("F_c1_valid", a_out_valid, 0);
        cyc();
        chk("F_relock", a_sel[14:10], 5'b00001);
        repeat (3) cyc();
        for (int j = 0; j < 5; j++) chk("sb_empty", sb[j].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
